cpu_fetch: RTL and testbench
============================

CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter: ADDR_W, default 8, program-counter and memory address width.
REQ-002 Parameter: TIMEOUT, default 15, ack-wait limit in cycles; used only with CPU_FETCH_TIMEOUT_EN.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 state  input  8  controller state code (0x01 FETCH_PC, 0x02 FETCH_INST, 0x03 HALT, 0x04 JUMP, 0x0F RET).
REQ-006 ret_addr  input  ADDR_W  return address popped from stack, used on RET.
REQ-007 mem_req  output  1  memory read request.
REQ-008 mem_addr  output  ADDR_W  read address, valid while mem_req=1.
REQ-009 mem_rdata  input  8  read data, valid when mem_ack=1.
REQ-010 mem_ack  input  1  read completion strobe, sampled only while mem_req=1.
REQ-011 instruction  output  8  instruction register presented to controller.
REQ-012 operand  output  8  last fetched byte.
REQ-013 pc  output  ADDR_W  current program counter.
REQ-014 stall  output  1  high while a fetch is outstanding; controller holds its cycle counter.
REQ-015 halted  output  1  sticky halt indication.
REQ-016 bus_err  output  1  sticky ack-timeout flag (constant 0 when timeout compiled out).

Function
REQ-017 Internal FSM SHALL have states IDLE, REQ, HALTED.
REQ-018 IDLE with state=0x01: next edge -> REQ, mem_req=1, mem_addr=pc.
REQ-019 REQ: mem_req and mem_addr held stable until an edge samples mem_ack=1.
REQ-020 On that edge: operand<=mem_rdata, pc<=pc+1 (modulo 2^ADDR_W, 0xFF->0x00), mem_req<=0, FSM -> IDLE.
REQ-021 Zero-wait ack SHALL complete a fetch with mem_req high for exactly one cycle.
REQ-022 stall SHALL equal (FSM==REQ), combinationally.
REQ-023 IDLE with state=0x02: instruction<=operand on next edge; pc unchanged.
REQ-024 IDLE with state=0x04: pc<=operand[ADDR_W-1:0]; state=0x0F: pc<=ret_addr.
REQ-025 JUMP/RET seen during REQ SHALL be latched as pending; on ack edge the pending target overrides pc+1; operand still captured.
REQ-026 Pending redirect arriving on the ack edge itself SHALL be applied on that edge with the same priority.
REQ-027 state=0x03 in IDLE -> HALTED next edge; in REQ -> complete fetch, then HALTED.
REQ-028 HALTED: mem_req=0, stall=0, halted=1; all state inputs ignored; exit only by reset.
REQ-029 Unlisted state codes SHALL have no effect.
REQ-030 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-031 reset_n low SHALL immediately force FSM=IDLE, pc=0, instruction=0, operand=0, mem_req=0, halted=0, bus_err=0, pending cleared.
REQ-032 Reset during REQ SHALL abandon the fetch; a late mem_ack after release is ignored.
REQ-033 First fetch after release SHALL use address 0.

Configuration
REQ-034 Macro CPU_FETCH_TIMEOUT_EN defined: counter runs in REQ; after TIMEOUT cycles without ack, bus_err<=1, mem_req<=0, FSM -> HALTED, pc unchanged.
REQ-035 Macro undefined: no counter, bus_err tied 0, REQ waits indefinitely.

Verification
REQ-036 Reset, state=0x01, ack same cycle, rdata=0x10 -> operand=0x10, pc=1, mem_req high 1 cycle; then state=0x02 -> instruction=0x10.
REQ-037 pc=0xFF, fetch with rdata=0xAA -> pc=0x00, operand=0xAA.
REQ-038 Ack delayed 3 cycles -> stall high 3+1 cycles, mem_addr constant; then state=0x04 with operand=0x42 -> pc=0x42.
REQ-039 state=0x0F, ret_addr=0x33 asserted mid-REQ -> after ack pc=0x33, not pc+1.
REQ-040 state=0x03 mid-REQ -> fetch completes, halted=1, later state=0x01 issues no mem_req; reset_n low mid-REQ -> mem_req=0 immediately, pc=0.
REQ-041 With CPU_FETCH_TIMEOUT_EN, TIMEOUT=15, no ack -> bus_err=1 and halted=1 on 15th REQ cycle; without macro, mem_req still high after 100 cycles.

Source files
------------

// File: rtl/cpu_fetch.sv
// Instruction fetch unit: issues memory reads, tracks the PC, and handles redirects and halts.
// Optional ack-timeout watchdog enabled by defining CPU_FETCH_TIMEOUT_EN.
module cpu_fetch #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        state,
    input  logic [ADDR_W-1:0] ret_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [7:0]        instruction,
    output logic [7:0]        operand,
    output logic [ADDR_W-1:0] pc,
    output logic              stall,
    output logic              halted,
    output logic              bus_err
);

    localparam logic [7:0] ST_FETCH_PC   = 8'h01;
    localparam logic [7:0] ST_FETCH_INST = 8'h02;
    localparam logic [7:0] ST_HALT       = 8'h03;
    localparam logic [7:0] ST_JUMP       = 8'h04;
    localparam logic [7:0] ST_RET        = 8'h0F;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_HALTED = 2'd2
    } fsm_e;

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("cpu_fetch: TIMEOUT must be nonzero");
    end

    fsm_e              fsm_q, fsm_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] redir_q, redir_d;
    logic              redir_vld_q, redir_vld_d;
    logic              halt_pend_q, halt_pend_d;
    logic [7:0]        instruction_q, instruction_d;
    logic [7:0]        operand_q, operand_d;
    logic              mem_req_q, mem_req_d;
    logic              halted_q, halted_d;

`ifdef CPU_FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q         <= S_IDLE;
            pc_q          <= '0;
            redir_q       <= '0;
            redir_vld_q   <= 1'b0;
            halt_pend_q   <= 1'b0;
            instruction_q <= '0;
            operand_q     <= '0;
            mem_req_q     <= 1'b0;
            halted_q      <= 1'b0;
`ifdef CPU_FETCH_TIMEOUT_EN
            cnt_q         <= '0;
            bus_err_q     <= 1'b0;
`endif
        end else begin
            fsm_q         <= fsm_d;
            pc_q          <= pc_d;
            redir_q       <= redir_d;
            redir_vld_q   <= redir_vld_d;
            halt_pend_q   <= halt_pend_d;
            instruction_q <= instruction_d;
            operand_q     <= operand_d;
            mem_req_q     <= mem_req_d;
            halted_q      <= halted_d;
`ifdef CPU_FETCH_TIMEOUT_EN
            cnt_q         <= cnt_d;
            bus_err_q     <= bus_err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d         = fsm_q;
        pc_d          = pc_q;
        redir_d       = redir_q;
        redir_vld_d   = redir_vld_q;
        halt_pend_d   = halt_pend_q;
        instruction_d = instruction_q;
        operand_d     = operand_q;
        mem_req_d     = mem_req_q;
        halted_d      = halted_q;
`ifdef CPU_FETCH_TIMEOUT_EN
        cnt_d         = '0;
        bus_err_d     = bus_err_q;
`endif

        case (fsm_q)
            S_IDLE: begin
                case (state)
                    ST_FETCH_PC: begin
                        fsm_d     = S_REQ;
                        mem_req_d = 1'b1;
                    end
                    ST_FETCH_INST: instruction_d = operand_q;
                    ST_HALT: begin
                        fsm_d    = S_HALTED;
                        halted_d = 1'b1;
                    end
                    ST_JUMP: pc_d = ADDR_W'(operand_q);
                    ST_RET:  pc_d = ret_addr;
                    default: ;
                endcase
            end

            S_REQ: begin
                // Requests seen during the fetch, including on the ack edge, are queued; latest redirect wins
                if (state == ST_JUMP) begin
                    redir_vld_d = 1'b1;
                    redir_d     = ADDR_W'(operand_q);
                end else if (state == ST_RET) begin
                    redir_vld_d = 1'b1;
                    redir_d     = ret_addr;
                end
                if (state == ST_HALT) begin
                    halt_pend_d = 1'b1;
                end

                if (mem_ack) begin
                    operand_d   = mem_rdata;
                    pc_d        = redir_vld_d ? redir_d : pc_q + ADDR_W'(1);
                    mem_req_d   = 1'b0;
                    fsm_d       = halt_pend_d ? S_HALTED : S_IDLE;
                    halted_d    = halt_pend_d;
                    redir_vld_d = 1'b0;
                    halt_pend_d = 1'b0;
                end
`ifdef CPU_FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    bus_err_d   = 1'b1;
                    mem_req_d   = 1'b0;
                    fsm_d       = S_HALTED;
                    halted_d    = 1'b1;
                    redir_vld_d = 1'b0;
                    halt_pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            S_HALTED: ;

            default: fsm_d = S_IDLE;
        endcase
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign instruction = instruction_q;
    assign operand     = operand_q;
    assign pc          = pc_q;
    assign stall       = (fsm_q == S_REQ);
    assign halted      = halted_q;
`ifdef CPU_FETCH_TIMEOUT_EN
    assign bus_err     = bus_err_q;
`else
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: directed scenarios plus randomized fetch/redirect traffic
// checked against a transaction-level reference model.
module tb_cpu_fetch;

    localparam int unsigned AW = 8;
    localparam int unsigned TO = 15;

    logic          clk;
    logic          reset_n;
    logic [7:0]    state;
    logic [AW-1:0] ret_addr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          mem_ack;
    logic [7:0]    instruction;
    logic [7:0]    operand;
    logic [AW-1:0] pc;
    logic          stall;
    logic          halted;
    logic          bus_err;

    cpu_fetch #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .state       (state),
        .ret_addr    (ret_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instruction (instruction),
        .operand     (operand),
        .pc          (pc),
        .stall       (stall),
        .halted      (halted),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural view only
    int m_pc;
    int m_op;
    int m_instr;
    int m_halted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_pc = 0; m_op = 0; m_instr = 0; m_halted = 0;
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, ".pc"},     32'(pc),          32'(m_pc));
        chk({tag, ".op"},     32'(operand),     32'(m_op));
        chk({tag, ".instr"},  32'(instruction), 32'(m_instr));
        chk({tag, ".halted"}, 32'(halted),      32'(m_halted));
        chk({tag, ".req"},    32'(mem_req),     32'(0));
        chk({tag, ".stall"},  32'(stall),       32'(0));
    endtask

    // One fetch: wait_n idle-ack cycles, optional RET or HALT seen in the first REQ cycle
    task automatic do_fetch(input string tag, input int wait_n, input logic [7:0] rdata,
                            input bit ret_mid, input logic [AW-1:0] ret_tgt, input bit halt_mid);
        int stall_cnt;
        int addr0;
        stall_cnt = 0;
        addr0 = m_pc;
        state = 8'h01; mem_ack = 1'b0;
        step();
        chk({tag, ".req_up"}, 32'(mem_req), 32'(1));
        for (int i = 0; i <= wait_n; i++) begin
            stall_cnt += int'(stall);
            chk({tag, ".addr"}, 32'(mem_addr), 32'(addr0));
            if (i > 0) chk({tag, ".req_hold"}, 32'(mem_req), 32'(1));
            state     = (i == 0 && ret_mid) ? 8'h0F : ((i == 0 && halt_mid) ? 8'h03 : 8'h00);
            ret_addr  = ret_tgt;
            mem_ack   = (i == wait_n);
            mem_rdata = (i == wait_n) ? rdata : 8'($urandom);
            step();
        end
        state = 8'h00; mem_ack = 1'b0;
        m_op = int'(rdata);
        m_pc = ret_mid ? int'(ret_tgt) : (m_pc + 1) % (1 << AW);
        if (halt_mid) m_halted = 1;
        chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(wait_n + 1));
        chk_arch(tag);
    endtask

    // One IDLE-cycle controller command with a stray ack that must be ignored
    task automatic idle_op(input string tag, input logic [7:0] code, input logic [AW-1:0] ra);
        state = code; ret_addr = ra;
        mem_ack = 1'($urandom); mem_rdata = 8'($urandom);
        step();
        state = 8'h00; mem_ack = 1'b0;
        if (m_halted == 0) begin
            case (code)
                8'h02: m_instr = m_op;
                8'h04: m_pc = m_op % (1 << AW);
                8'h0F: m_pc = int'(ra);
                default: ;
            endcase
        end
        chk_arch(tag);
    endtask

    initial begin
        logic [7:0]    code;
        logic [7:0]    rd;
        logic [AW-1:0] tgt;
        int            w;
        bit            rm;
        int            sel;

        reset_n = 1'b0; state = 8'h00; ret_addr = '0;
        mem_rdata = 8'h00; mem_ack = 1'b0;
        model_reset();
        step(); step();
        chk("rst.bus_err", 32'(bus_err), 32'(0));
        chk_arch("rst");
        reset_n = 1'b1;
        step();

        // Zero-wait fetch then instruction load
        do_fetch("f0", 0, 8'h10, 1'b0, '0, 1'b0);
        idle_op("inst0", 8'h02, '0);

        // PC wrap
        idle_op("ret_ff", 8'h0F, 8'hFF);
        do_fetch("wrap", 1, 8'hAA, 1'b0, '0, 1'b0);

        // Delayed ack, then jump to fetched operand
        do_fetch("w3", 3, 8'h42, 1'b0, '0, 1'b0);
        idle_op("jmp42", 8'h04, '0);

        // RET mid-fetch overrides pc+1; also on the ack edge itself
        do_fetch("retmid", 2, 8'h5C, 1'b1, 8'h33, 1'b0);
        do_fetch("retack", 0, 8'h77, 1'b1, 8'h91, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 5));
            tgt = AW'($urandom);
            case (sel)
                0: idle_op("r_inst", 8'h02, tgt);
                1: idle_op("r_jmp", 8'h04, tgt);
                2: idle_op("r_ret", 8'h0F, tgt);
                3: begin
                    code = 8'($urandom);
                    if (code inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h0F}) code = 8'h55;
                    idle_op("r_nop", code, tgt);
                end
                default: ;
            endcase
            w  = int'($urandom_range(0, 4));
            rd = 8'($urandom);
            rm = ($urandom_range(0, 3) == 0);
            tgt = AW'($urandom);
            do_fetch("r_fetch", w, rd, rm, tgt, 1'b0);
        end

        // Reset in the middle of a fetch
        state = 8'h01; step();
        state = 8'h00;
        chk("rmid.req_before", 32'(mem_req), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("rmid.req", 32'(mem_req), 32'(0));
        chk("rmid.pc", 32'(pc), 32'(0));
        chk("rmid.stall", 32'(stall), 32'(0));
        step();
        reset_n = 1'b1;
        model_reset();
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        step();
        mem_ack = 1'b0;
        chk_arch("late_ack");
        do_fetch("after_rst", 1, 8'h21, 1'b0, '0, 1'b0);

        // Halt requested mid-fetch: fetch completes, then everything ignored
        do_fetch("haltmid", 2, 8'h66, 1'b0, '0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            state = 8'h01; step();
            chk("halt.req", 32'(mem_req), 32'(0));
            chk("halt.stall", 32'(stall), 32'(0));
        end
        state = 8'h00;
        idle_op("halt_jmp", 8'h04, '0);
        idle_op("halt_ret", 8'h0F, 8'h12);

        // Ack never arrives
        reset_n = 1'b0; step();
        reset_n = 1'b1; model_reset(); step();
        state = 8'h01; step();
        state = 8'h00;
`ifdef CPU_FETCH_TIMEOUT_EN
        for (int n = 0; n < TO; n++) step();
        chk("to.bus_err", 32'(bus_err), 32'(1));
        chk("to.halted", 32'(halted), 32'(1));
        chk("to.req", 32'(mem_req), 32'(0));
        chk("to.pc", 32'(pc), 32'(0));
`else
        for (int n = 0; n < 100; n++) step();
        chk("noto.req", 32'(mem_req), 32'(1));
        chk("noto.stall", 32'(stall), 32'(1));
        chk("noto.bus_err", 32'(bus_err), 32'(0));
        chk("noto.addr", 32'(mem_addr), 32'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
